// File: rtl/timekeep_if.sv
// Control pulses/levels into the timekeeper and the time fields and tick strobes back out.
// Latency and backpressure: none; this is just wiring.
interface timekeep_if #(
    parameter int TICK_HZ  = 100,
    parameter int SEC_MOD  = 60,
    parameter int HOUR_MOD = 24
);
    logic                        run;
    logic                        clear;
    logic                        dir;
    logic                        i_sec;
    logic                        i_min;
    logic                        i_hour;
    logic [$clog2(TICK_HZ)-1:0]  csec;
    logic [$clog2(SEC_MOD)-1:0]  sec;
    logic [$clog2(SEC_MOD)-1:0]  min;
    logic [$clog2(HOUR_MOD)-1:0] hour;
    logic                        tick_base;
    logic                        tick_1s;
    logic                        done;

    modport master (
        output run, clear, dir, i_sec, i_min, i_hour,
        input  csec, sec, min, hour, tick_base, tick_1s, done
    );

    modport slave (
        input  run, clear, dir, i_sec, i_min, i_hour,
        output csec, sec, min, hour, tick_base, tick_1s, done
    );
endinterface

// File: rtl/timekeep_core.sv
// Clock/stopwatch/timer: prescaled tick drives an up/down csec-sec-min-hour cascade; fields update one edge after a tick.
// Backpressure: none; run gates the prescaler, done freezes it after a down-count reaches zero.
module timekeep_core #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 100,
    parameter int SEC_MOD   = 60,
    parameter int HOUR_MOD  = 24,
    parameter int HOUR_INIT = 12
) (
    input  logic       clk,
    input  logic       reset,
    timekeep_if.slave  bus
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW  = $clog2(TICK_HZ);
    localparam int SW  = $clog2(SEC_MOD);
    localparam int HW  = $clog2(HOUR_MOD);

    if (DIV < 2) begin : g_bad_div
        $error("timekeep_core: CLK_HZ/TICK_HZ must be at least 2");
    end
    if (HOUR_INIT >= HOUR_MOD) begin : g_bad_init
        $error("timekeep_core: HOUR_INIT must be below HOUR_MOD");
    end

    logic [PW-1:0] pre_cnt;
    logic [CW-1:0] csec_q, csec_n;
    logic [SW-1:0] sec_q, sec_n;
    logic [SW-1:0] min_q, min_n;
    logic [HW-1:0] hour_q, hour_n;
    logic          done_q;

    logic adv, tick, all_zero;
    logic c_edge, s_edge, m_edge;

    assign adv      = bus.run && !done_q;
    assign tick     = adv && (pre_cnt == PW'(DIV - 1)) && !bus.clear;
    assign all_zero = (csec_q == '0) && (sec_q == '0) && (min_q == '0) && (hour_q == '0);

    // A field "edge" is the value that wraps (up) or borrows (down) on the next step.
    assign c_edge = bus.dir ? (csec_q == '0) : (csec_q == CW'(TICK_HZ - 1));
    assign s_edge = bus.dir ? (sec_q  == '0) : (sec_q  == SW'(SEC_MOD - 1));
    assign m_edge = bus.dir ? (min_q  == '0) : (min_q  == SW'(SEC_MOD - 1));

    always_comb begin
        csec_n = csec_q;
        sec_n  = sec_q;
        min_n  = min_q;
        hour_n = hour_q;
        if (bus.dir) begin
            csec_n = c_edge ? CW'(TICK_HZ - 1) : csec_q - CW'(1);
            if (c_edge)
                sec_n = s_edge ? SW'(SEC_MOD - 1) : sec_q - SW'(1);
            if (c_edge && s_edge)
                min_n = m_edge ? SW'(SEC_MOD - 1) : min_q - SW'(1);
            if (c_edge && s_edge && m_edge)
                hour_n = (hour_q == '0) ? HW'(HOUR_MOD - 1) : hour_q - HW'(1);
        end else begin
            csec_n = c_edge ? '0 : csec_q + CW'(1);
            if (c_edge)
                sec_n = s_edge ? '0 : sec_q + SW'(1);
            if (c_edge && s_edge)
                min_n = m_edge ? '0 : min_q + SW'(1);
            if (c_edge && s_edge && m_edge)
                hour_n = (hour_q == HW'(HOUR_MOD - 1)) ? '0 : hour_q + HW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
            csec_q  <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= HW'(HOUR_INIT);
            done_q  <= 1'b0;
        end else if (bus.clear) begin
            pre_cnt <= '0;
            csec_q  <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= HW'(HOUR_INIT);
            done_q  <= 1'b0;
        end else begin
            // Sets only apply while stopped, so they never collide with a tick.
            if (!bus.run) begin
                if (bus.i_sec)
                    sec_q <= (sec_q == SW'(SEC_MOD - 1)) ? '0 : sec_q + SW'(1);
                if (bus.i_min)
                    min_q <= (min_q == SW'(SEC_MOD - 1)) ? '0 : min_q + SW'(1);
                if (bus.i_hour)
                    hour_q <= (hour_q == HW'(HOUR_MOD - 1)) ? '0 : hour_q + HW'(1);
            end else if (tick) begin
                if (bus.dir && all_zero) begin
                    done_q <= 1'b1;
                end else begin
                    csec_q <= csec_n;
                    sec_q  <= sec_n;
                    min_q  <= min_n;
                    hour_q <= hour_n;
                end
            end
            if (adv)
                pre_cnt <= (pre_cnt == PW'(DIV - 1)) ? '0 : pre_cnt + PW'(1);
        end
    end

    assign bus.csec      = csec_q;
    assign bus.sec       = sec_q;
    assign bus.min       = min_q;
    assign bus.hour      = hour_q;
    assign bus.done      = done_q;
    assign bus.tick_base = tick;
    assign bus.tick_1s   = tick && c_edge && !(bus.dir && all_zero);
endmodule

// File: tb/tb_timekeep_core.sv
// Randomized and directed bench for timekeep_core; the reference model keeps time as a
// single count of sub-second units and decomposes it into fields for comparison.
module tb_timekeep_core;
    localparam int CLK_HZ    = 1000;
    localparam int TICK_HZ   = 10;
    localparam int SEC_MOD   = 60;
    localparam int HOUR_MOD  = 24;
    localparam int HOUR_INIT = 12;
    localparam int DIV       = CLK_HZ / TICK_HZ;
    localparam int U_SEC     = TICK_HZ;
    localparam int U_MIN     = TICK_HZ * SEC_MOD;
    localparam int U_HOUR    = TICK_HZ * SEC_MOD * SEC_MOD;
    localparam int DAY       = U_HOUR * HOUR_MOD;
    localparam int INIT_TOT  = HOUR_INIT * U_HOUR;

    logic clk;
    logic reset;

    timekeep_if #(.TICK_HZ(TICK_HZ), .SEC_MOD(SEC_MOD), .HOUR_MOD(HOUR_MOD)) tk ();

    timekeep_core #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .SEC_MOD(SEC_MOD),
        .HOUR_MOD(HOUR_MOD), .HOUR_INIT(HOUR_INIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tk.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int  m_total;
    int  m_phase;
    bit  m_done;
    int  obs_tb;
    int  obs_1s;
    int  cyc_no;
    int  first_tb;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_fields(input string tag);
        check({tag, ".csec"}, int'(tk.csec), m_total % TICK_HZ);
        check({tag, ".sec"},  int'(tk.sec),  (m_total / U_SEC) % SEC_MOD);
        check({tag, ".min"},  int'(tk.min),  (m_total / U_MIN) % SEC_MOD);
        check({tag, ".hour"}, int'(tk.hour), m_total / U_HOUR);
        check({tag, ".done"}, int'(tk.done), int'(m_done));
    endtask

    // One clock: drive at negedge, compare, then advance the model across the posedge.
    task automatic cyc(input bit r, input bit c, input bit d, input bit s, input bit mi, input bit h);
        bit adv, tk_, e1s;
        int fc, fs, fm, fh;
        tk.run = r; tk.clear = c; tk.dir = d;
        tk.i_sec = s; tk.i_min = mi; tk.i_hour = h;
        #1;
        adv = r && !m_done;
        tk_ = adv && (m_phase == DIV - 1) && !c;
        e1s = tk_ && (d ? ((m_total % TICK_HZ == 0) && (m_total != 0))
                        : (m_total % TICK_HZ == TICK_HZ - 1));
        check("tick_base", int'(tk.tick_base), int'(tk_));
        check("tick_1s",   int'(tk.tick_1s),   int'(e1s));
        check_fields("cyc");
        obs_tb += int'(tk.tick_base);
        obs_1s += int'(tk.tick_1s);
        if (tk.tick_base && first_tb < 0) first_tb = cyc_no;
        cyc_no++;
        @(posedge clk);
        if (c) begin
            m_total = INIT_TOT; m_phase = 0; m_done = 0;
        end else begin
            if (!r) begin
                fc = m_total % TICK_HZ;
                fs = (m_total / U_SEC) % SEC_MOD;
                fm = (m_total / U_MIN) % SEC_MOD;
                fh = m_total / U_HOUR;
                if (s)  fs = (fs + 1) % SEC_MOD;
                if (mi) fm = (fm + 1) % SEC_MOD;
                if (h)  fh = (fh + 1) % HOUR_MOD;
                m_total = fh * U_HOUR + fm * U_MIN + fs * U_SEC + fc;
            end else if (tk_) begin
                if (d) begin
                    if (m_total == 0) m_done = 1;
                    else m_total = m_total - 1;
                end else begin
                    m_total = (m_total + 1) % DAY;
                end
            end
            if (adv) m_phase = (m_phase + 1) % DIV;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        tk.run = 0; tk.clear = 0; tk.dir = 0;
        tk.i_sec = 0; tk.i_min = 0; tk.i_hour = 0;
        reset = 1'b1;
        m_total = INIT_TOT; m_phase = 0; m_done = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst.csec", int'(tk.csec), 0);
        check("rst.hour", int'(tk.hour), HOUR_INIT);
        check("rst.tick_base", int'(tk.tick_base), 0);
        check("rst.done", int'(tk.done), 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bit r_lvl, d_lvl;
        reset    = 1'b1;
        obs_tb   = 0;
        obs_1s   = 0;
        cyc_no   = 0;
        first_tb = -1;
        @(negedge clk);
        do_reset();

        // Free run for one second of simulated time.
        cyc_no = 0; first_tb = -1; obs_tb = 0; obs_1s = 0;
        repeat (1000) cyc(1, 0, 0, 0, 0, 0);
        check("run1s.first_tick_cyc", first_tb, DIV - 1);
        check("run1s.tick_base_cnt", obs_tb, 10);
        check("run1s.tick_1s_cnt", obs_1s, 1);
        check("run1s.sec", int'(tk.sec), 1);
        check("run1s.csec", int'(tk.csec), 0);
        check("run1s.hour", int'(tk.hour), 12);

        // 11:59:59.9 rolls to 12:00:00.0 on one tick.
        cyc(0, 1, 0, 0, 0, 0);
        repeat (9 * DIV) cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 59; i++) cyc(0, 0, 0, 1, 1, (i < 23));
        check("preset.hour", int'(tk.hour), 11);
        check("preset.min", int'(tk.min), 59);
        check("preset.sec", int'(tk.sec), 59);
        check("preset.csec", int'(tk.csec), 9);
        obs_1s = 0;
        repeat (DIV) cyc(1, 0, 0, 0, 0, 0);
        check("roll.hour", int'(tk.hour), 12);
        check("roll.min", int'(tk.min), 0);
        check("roll.sec", int'(tk.sec), 0);
        check("roll.csec", int'(tk.csec), 0);
        check("roll.tick_1s_cnt", obs_1s, 1);

        // Count down from 00:00:01.0 to done.
        cyc(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 12; i++) cyc(0, 0, 1, (i == 0), 0, 1);
        check("down.preset.hour", int'(tk.hour), 0);
        repeat (DIV) cyc(1, 0, 1, 0, 0, 0);
        check("down.first.csec", int'(tk.csec), 9);
        check("down.first.sec", int'(tk.sec), 0);
        repeat (9 * DIV) cyc(1, 0, 1, 0, 0, 0);
        check("down.zero.csec", int'(tk.csec), 0);
        check("down.zero.done", int'(tk.done), 0);
        repeat (DIV) cyc(1, 0, 1, 0, 0, 0);
        check("down.done", int'(tk.done), 1);
        obs_tb = 0;
        repeat (3 * DIV) cyc(1, 0, 1, 0, 0, 0);
        check("down.frozen.tick_cnt", obs_tb, 0);
        repeat (5) cyc(1, 0, 0, 0, 0, 0);
        check("down.dir0.done", int'(tk.done), 1);

        // Set pulses while stopped wrap without carry; ignored while running.
        cyc(0, 1, 0, 0, 0, 0);
        repeat (61) cyc(0, 0, 0, 0, 1, 0);
        check("set.min", int'(tk.min), 1);
        check("set.hour", int'(tk.hour), 12);
        repeat (3) cyc(1, 0, 0, 1, 0, 0);
        check("set.run.sec", int'(tk.sec), 0);

        // Clear beats a set and a tick.
        repeat (3) cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 1, 0, 0);
        check("clr_set.sec", int'(tk.sec), 0);
        repeat (DIV - 1) cyc(1, 0, 0, 0, 0, 0);
        obs_tb = 0;
        cyc(1, 1, 0, 0, 0, 0);
        check("clr_tick.tick_cnt", obs_tb, 0);
        check("clr_tick.csec", int'(tk.csec), 0);

        // Randomized levels and pulses against the model.
        r_lvl = 1; d_lvl = 0;
        for (int i = 0; i < 15000; i++) begin
            if ($urandom % 60 == 0)  r_lvl = !r_lvl;
            if ($urandom % 500 == 0) d_lvl = !d_lvl;
            cyc(r_lvl, ($urandom % 700 == 0), d_lvl,
                ($urandom % 3 == 0), ($urandom % 3 == 0), ($urandom % 4 == 0));
        end

        // Asynchronous reset between edges.
        repeat (250) cyc(1, 0, 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        check("arst.csec", int'(tk.csec), 0);
        check("arst.sec", int'(tk.sec), 0);
        check("arst.hour", int'(tk.hour), HOUR_INIT);
        check("arst.tick_base", int'(tk.tick_base), 0);
        @(negedge clk);
        do_reset();
        cyc(0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/timekeep_core.md
TIMEKEEP_CORE -- requirements
Module: timekeep_core

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 100, base tick rate in Hz; also the sub-second modulus.
REQ-003 Parameter SEC_MOD, default 60, modulus of the seconds field and the minutes field.
REQ-004 Parameter HOUR_MOD, default 24, modulus of the hours field.
REQ-005 Parameter HOUR_INIT, default 12, hour value loaded on reset or clear; must be less than HOUR_MOD.
REQ-006 Derived DIV = CLK_HZ/TICK_HZ; a value below 2 is a configuration error.
REQ-007 clk  in  1  single system clock; all state on rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 run  in  1  level; 1 = prescaler and cascade advance.
REQ-010 clear  in  1  synchronous pulse; returns time state to initial values.
REQ-011 dir  in  1  level; 0 = count up (clock/stopwatch), 1 = count down (timer).
REQ-012 i_sec, i_min, i_hour  in  1 each  one-cycle set pulses, one per field.
REQ-013 csec  out  $clog2(TICK_HZ)  sub-second field.
REQ-014 sec, min  out  $clog2(SEC_MOD) each  seconds and minutes fields.
REQ-015 hour  out  $clog2(HOUR_MOD)  hours field.
REQ-016 tick_base  out  1  one-cycle pulse per prescaler terminal count.
REQ-017 tick_1s  out  1  one-cycle pulse per csec wrap or borrow.
REQ-018 done  out  1  sticky; down-count has reached all-zero.

Function
REQ-019 Prescaler counts 0..DIV-1 while run=1 and done=0; holds otherwise; wraps to 0 after DIV-1.
REQ-020 tick_base=1 for the single cycle the prescaler is at DIV-1 and advancing; the tick comes every DIV cycles of run.
REQ-021 Up mode, per tick: csec+1; a wrap from TICK_HZ-1 to 0 carries into sec; sec 59->0 carries into min; min 59->0 carries into hour; hour HOUR_MOD-1->0 with no further carry.
REQ-022 Down mode, per tick: csec-1; a borrow from 0 to TICK_HZ-1 decrements sec; sec and min borrow from 0 to SEC_MOD-1 in the same way; hour borrows from 0 to HOUR_MOD-1.
REQ-023 All carries and borrows resolve in the same edge as the tick; fields never show intermediate values.
REQ-024 tick_1s is asserted in the same cycle as the tick that causes a csec wrap or borrow.
REQ-025 Down mode, tick while all four fields = 0: fields hold at 0, done is set on that edge, and the prescaler freezes.
REQ-026 done clears only on clear or reset; changing dir does not clear it.
REQ-027 Set pulses act only when run=0: i_sec and i_min add 1 modulo SEC_MOD, i_hour adds 1 modulo HOUR_MOD, with no carry into other fields.
REQ-028 Set pulses received while run=1 are ignored; simultaneous pulses on different fields each apply.
REQ-029 Priority: clear > set > tick.
REQ-030 clear: csec, sec, min and prescaler -> 0; hour -> HOUR_INIT; done -> 0; tick outputs 0 in that cycle.
REQ-031 A dir change takes effect on the next tick; the prescaler phase is preserved.
REQ-032 All outputs are registered, except tick_base and tick_1s, which may be decoded from registered state.

Reset
REQ-033 While reset=1: prescaler=0, csec=0, sec=0, min=0, hour=HOUR_INIT, done=0, tick_base=0, tick_1s=0; reset mid-count aborts immediately.
REQ-034 After reset deasserts, the first tick_base occurs DIV cycles after run is first sampled 1.

Verification (CLK_HZ=1000, TICK_HZ=10, so DIV=100; other params default)
REQ-035 Reset, then run=1 for 1000 cycles -> tick_base pulses 10 times; csec=0, sec=1, tick_1s pulses once; hour=12.
REQ-036 Up mode, preset 11:59:59 csec=9 (hour set from 12 by wrap through 0..11) -> after one tick: 12:00:00 csec=0, tick_1s=1.
REQ-037 dir=1, preset 00:00:01 csec=0, run=1 -> 00:00:00 csec=9 after one tick; all fields 0 after 10 ticks; done=1 on the next tick, fields held, tick_base stops.
REQ-038 run=0: i_min pulsed 61 times -> min=1, hour unchanged; i_sec pulsed with run=1 -> sec unchanged.
REQ-039 clear and i_sec in the same cycle, and clear during a tick -> all fields initial, done=0, no set applied.
REQ-040 reset asserted mid-run between clock edges -> outputs take reset values before the next clk edge.
